// File: rtl/id_issue_ctrl_pkg.sv
// Shared types and RV32I opcode constants for the decode-stage issue controller.
// Also holds the register-usage helpers used by hazard detection.
package id_issue_ctrl_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_B_TYPE = 7'b1100011;
   localparam logic [6:0] OP_I_TYPE = 7'b0010011;
   localparam logic [6:0] OP_R_TYPE = 7'b0110011;

   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   function automatic logic reads_rs1(input logic [6:0] opcode);
      return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
   endfunction

   function automatic logic reads_rs2(input logic [6:0] opcode);
      return (opcode == OP_R_TYPE || opcode == OP_STORE || opcode == OP_B_TYPE);
   endfunction

endpackage

// File: rtl/id_issue_ctrl_hazard_detect.sv
// Combinational load-use hazard check of the decode-stage instruction against the EX load.
// x0 is never a hazard source since writes to it are discarded.
module id_hazard_detect
   import id_issue_ctrl_pkg::*;
(
   input  logic       id_valid,
   input  logic [6:0] opcode,
   input  logic [4:0] rs1,
   input  logic [4:0] rs2,
   input  logic       ex_valid,
   input  logic       ex_is_load,
   input  logic [4:0] ex_rd,
   output logic       load_use
);

   logic use_rs1;
   logic use_rs2;
   logic rs1_hit;
   logic rs2_hit;

   assign use_rs1 = reads_rs1(opcode);
   assign use_rs2 = reads_rs2(opcode);
   assign rs1_hit = use_rs1 && (rs1 == ex_rd);
   assign rs2_hit = use_rs2 && (rs2 == ex_rd);

   assign load_use = id_valid && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                     (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_issue_ctrl.sv
// IF/ID register plus issue/flush control: zero-bubble issue, one bubble per load-use,
// fetch held FLUSH_CYCLES after a redirect. Optional stall counter under PERF_CNT_EN.
module id_issue_ctrl
   import id_issue_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEF,
   parameter int unsigned PERF_W       = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_valid,
   output logic        if_ready,
   input  logic [31:0] if_instr,
   input  logic [31:0] if_pc,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   input  logic [6:0]  dec_opcode,
   input  logic [4:0]  dec_rs1,
   input  logic [4:0]  dec_rs2,
   input  logic        ex_ready,
   input  logic        ex_valid,
   input  logic        ex_is_load,
   input  logic [4:0]  ex_rd,
   input  logic        redirect,
   output logic        issue,
   output logic        load_use
`ifdef PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] stall_cnt
`endif
);

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] flush_cnt;

   id_hazard_detect u_hazard (
      .id_valid   (id_valid),
      .opcode     (dec_opcode),
      .rs1        (dec_rs1),
      .rs2        (dec_rs2),
      .ex_valid   (ex_valid),
      .ex_is_load (ex_is_load),
      .ex_rd      (ex_rd),
      .load_use   (load_use)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // A redirect from any state (re)starts the flush window.
   always_comb begin
      state_nxt = state;
      if (redirect) begin
         state_nxt = ST_FLUSH;
      end else if (state == ST_FLUSH && flush_cnt == 4'd1) begin
         state_nxt = ST_RUN;
      end
   end

   always_comb begin
      issue    = 1'b0;
      if_ready = 1'b0;
      if (state == ST_RUN && !redirect) begin
         issue    = id_valid && ex_ready && !load_use;
         if_ready = !id_valid || issue;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flush_cnt <= 4'd0;
      end else if (redirect) begin
         flush_cnt <= FLUSH_LOAD;
      end else if (state == ST_FLUSH && flush_cnt != 4'd0) begin
         flush_cnt <= flush_cnt - 4'd1;
      end
   end

   // Fetch acceptance has priority over issue so back-to-back words overwrite in place.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         id_valid <= 1'b0;
         id_instr <= NOP_INSTR;
         id_pc    <= 32'd0;
      end else if (redirect) begin
         id_valid <= 1'b0;
         id_instr <= NOP_INSTR;
      end else if (if_valid && if_ready) begin
         id_valid <= 1'b1;
         id_instr <= if_instr;
         id_pc    <= if_pc;
      end else if (issue) begin
         id_valid <= 1'b0;
         id_instr <= NOP_INSTR;
      end
   end

`ifdef PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if ((load_use || state == ST_FLUSH) && stall_cnt != {PERF_W{1'b1}}) begin
         stall_cnt <= stall_cnt + PERF_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl: vector table for hazard/issue decisions,
// hand sequences for reset, streaming, stall, redirect/flush and backpressure.
module tb_id_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [6:0]  dec_opcode;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;
   logic        ex_ready;
   logic        ex_valid;
   logic        ex_is_load;
   logic [4:0]  ex_rd;
   logic        redirect;
   logic        issue;
   logic        load_use;
`ifdef PERF_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   // Field extraction standing in for instr_decode.
   assign dec_opcode = id_instr[6:0];
   assign dec_rs1    = id_instr[19:15];
   assign dec_rs2    = id_instr[24:20];

   id_issue_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .if_valid   (if_valid),
      .if_ready   (if_ready),
      .if_instr   (if_instr),
      .if_pc      (if_pc),
      .id_valid   (id_valid),
      .id_instr   (id_instr),
      .id_pc      (id_pc),
      .dec_opcode (dec_opcode),
      .dec_rs1    (dec_rs1),
      .dec_rs2    (dec_rs2),
      .ex_ready   (ex_ready),
      .ex_valid   (ex_valid),
      .ex_is_load (ex_is_load),
      .ex_rd      (ex_rd),
      .redirect   (redirect),
      .issue      (issue),
      .load_use   (load_use)
`ifdef PERF_CNT_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   typedef struct {
      logic [31:0] instr;
      logic        ex_valid;
      logic        ex_is_load;
      logic [4:0]  ex_rd;
      logic        redirect;
      logic        exp_load_use;
      logic        exp_issue;
      logic        exp_if_ready;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      if_valid   = 1'b0;
      if_instr   = 32'd0;
      if_pc      = 32'd0;
      ex_ready   = 1'b1;
      ex_valid   = 1'b0;
      ex_is_load = 1'b0;
      ex_rd      = 5'd0;
      redirect   = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{32'h0012_8333, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0}; // add x6,x5,x1
      vecs[1]  = '{32'h0050_8333, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0}; // add x6,x1,x5
      vecs[2]  = '{32'h0012_8333, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1}; // rd=x0
      vecs[3]  = '{32'h0012_8333, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1}; // EX not a load
      vecs[4]  = '{32'h0012_8333, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1}; // EX empty
      vecs[5]  = '{32'h0002_82B7, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1}; // lui x5
      vecs[6]  = '{32'h0002_82EF, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1}; // jal x5
      vecs[7]  = '{32'h0002_8297, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1}; // auipc x5
      vecs[8]  = '{32'h0051_2023, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0}; // sw x5,0(x2)
      vecs[9]  = '{32'h0051_0393, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1}; // addi x7,x2,5
      vecs[10] = '{32'h0002_8063, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0}; // beq x5,x0
      vecs[11] = '{32'h0002_80E7, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0}; // jalr x1,0(x5)
      vecs[12] = '{32'h0012_8333, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0}; // hazard + redirect
      vecs[13] = '{32'h0000_0033, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1}; // add x0,x0,x0

      // Reset with fetch asserted.
      idle_inputs();
      rst_n    = 1'b0;
      if_valid = 1'b1;
      if_instr = 32'hDEAD_BEEF;
      if_pc    = 32'h0000_1000;
      tick();
      tick();
      chk("reset_id_valid", {31'd0, id_valid}, 32'd0);
      chk("reset_id_instr", id_instr, 32'h0000_0013);
      chk("reset_id_pc", id_pc, 32'd0);
      rst_n = 1'b1;
      if_valid = 1'b0;
      settle();
      chk("reset_if_ready", {31'd0, if_ready}, 32'd1);

      // Table-driven hazard / issue decisions.
      for (int i = 0; i < 14; i++) begin
         ex_ready = 1'b0;
         ex_valid = 1'b0;
         redirect = 1'b0;
         if_valid = 1'b1;
         if_instr = vecs[i].instr;
         if_pc    = 32'h100 + 32'(i * 4);
         tick();
         if_valid   = 1'b0;
         ex_valid   = vecs[i].ex_valid;
         ex_is_load = vecs[i].ex_is_load;
         ex_rd      = vecs[i].ex_rd;
         redirect   = vecs[i].redirect;
         ex_ready   = 1'b1;
         settle();
         chk($sformatf("vec%0d_load_use", i), {31'd0, load_use}, {31'd0, vecs[i].exp_load_use});
         chk($sformatf("vec%0d_issue", i), {31'd0, issue}, {31'd0, vecs[i].exp_issue});
         chk($sformatf("vec%0d_if_ready", i), {31'd0, if_ready}, {31'd0, vecs[i].exp_if_ready});
         tick();
         chk($sformatf("vec%0d_id_valid_after", i), {31'd0, id_valid},
             {31'd0, vecs[i].exp_load_use & ~vecs[i].redirect});
         idle_inputs();
         repeat (3) tick();
      end

      // Back-to-back stream of ALU instructions.
      idle_inputs();
      for (int k = 0; k < 4; k++) begin
         if_valid = 1'b1;
         if_instr = 32'h0000_0093 | (32'(k) << 20);
         if_pc    = 32'(k * 4);
         tick();
         chk($sformatf("stream%0d_pc", k), id_pc, 32'(k * 4));
         chk($sformatf("stream%0d_issue", k), {31'd0, issue}, 32'd1);
         chk($sformatf("stream%0d_if_ready", k), {31'd0, if_ready}, 32'd1);
      end
      if_valid = 1'b0;
      tick();
      chk("stream_drain_id_valid", {31'd0, id_valid}, 32'd0);

      // Load-use: one bubble, then issue.
      ex_valid   = 1'b1;
      ex_is_load = 1'b1;
      ex_rd      = 5'd5;
      if_valid   = 1'b1;
      if_instr   = 32'h0012_8333;
      if_pc      = 32'h80;
      tick();
      if_valid = 1'b0;
      settle();
      chk("lu_stall_load_use", {31'd0, load_use}, 32'd1);
      chk("lu_stall_issue", {31'd0, issue}, 32'd0);
      tick();
      ex_valid = 1'b0;
      settle();
      chk("lu_after_load_use", {31'd0, load_use}, 32'd0);
      chk("lu_after_issue", {31'd0, issue}, 32'd1);
      chk("lu_after_pc", id_pc, 32'h80);
      tick();
      chk("lu_drain_id_valid", {31'd0, id_valid}, 32'd0);
      idle_inputs();

      // Redirect with live IF/ID and a fetch pending.
      ex_ready = 1'b0;
      if_valid = 1'b1;
      if_instr = 32'h0000_0113;
      if_pc    = 32'h200;
      tick();
      if_instr = 32'h0000_0193;
      if_pc    = 32'h204;
      redirect = 1'b1;
      settle();
      chk("redir_issue", {31'd0, issue}, 32'd0);
      chk("redir_if_ready", {31'd0, if_ready}, 32'd0);
      tick();
      redirect = 1'b0;
      settle();
      chk("redir_flush_id_valid", {31'd0, id_valid}, 32'd0);
      chk("redir_flush_if_ready", {31'd0, if_ready}, 32'd0);
      tick();
      chk("redir_run_if_ready", {31'd0, if_ready}, 32'd1);

      // Second redirect during the flush window extends it.
      if_valid = 1'b0;
      redirect = 1'b1;
      tick();
      if_valid = 1'b1;
      redirect = 1'b1;
      settle();
      chk("redir2_if_ready", {31'd0, if_ready}, 32'd0);
      tick();
      redirect = 1'b0;
      settle();
      chk("redir2_hold_if_ready", {31'd0, if_ready}, 32'd0);
      chk("redir2_drop_id_valid", {31'd0, id_valid}, 32'd0);
      if_valid = 1'b0;
      tick();
      chk("redir2_run_if_ready", {31'd0, if_ready}, 32'd1);
      idle_inputs();

      // Backpressure holds IF/ID stable.
      ex_ready = 1'b0;
      if_valid = 1'b1;
      if_instr = 32'h0030_0213;
      if_pc    = 32'h40;
      tick();
      if_instr = 32'h0040_0293;
      if_pc    = 32'h44;
      for (int c = 0; c < 3; c++) begin
         settle();
         chk($sformatf("bp%0d_instr", c), id_instr, 32'h0030_0213);
         chk($sformatf("bp%0d_pc", c), id_pc, 32'h40);
         chk($sformatf("bp%0d_if_ready", c), {31'd0, if_ready}, 32'd0);
         tick();
      end
      ex_ready = 1'b1;
      settle();
      chk("bp_release_issue", {31'd0, issue}, 32'd1);
      chk("bp_release_if_ready", {31'd0, if_ready}, 32'd1);
      tick();
      chk("bp_next_pc", id_pc, 32'h44);
      idle_inputs();
      repeat (2) tick();

      // Reset during flush and during a stall.
      redirect = 1'b1;
      tick();
      redirect = 1'b0;
      settle();
      chk("rst_flush_pre_if_ready", {31'd0, if_ready}, 32'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      settle();
      chk("rst_flush_if_ready", {31'd0, if_ready}, 32'd1);
      ex_valid   = 1'b1;
      ex_is_load = 1'b1;
      ex_rd      = 5'd5;
      if_valid   = 1'b1;
      if_instr   = 32'h0012_8333;
      tick();
      if_valid = 1'b0;
      settle();
      chk("rst_stall_pre_load_use", {31'd0, load_use}, 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      settle();
      chk("rst_stall_id_valid", {31'd0, id_valid}, 32'd0);
      chk("rst_stall_id_instr", id_instr, 32'h0000_0013);
      idle_inputs();

`ifdef PERF_CNT_EN
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      settle();
      chk("perf_reset", stall_cnt, 32'd0);
      ex_valid   = 1'b1;
      ex_is_load = 1'b1;
      ex_rd      = 5'd5;
      if_valid   = 1'b1;
      if_instr   = 32'h0012_8333;
      tick();
      if_valid = 1'b0;
      tick();
      ex_valid = 1'b0;
      tick();
      redirect = 1'b1;
      tick();
      redirect = 1'b0;
      tick();
      settle();
      chk("perf_stall_cnt", stall_cnt, 32'd2);
      idle_inputs();
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
